sdram_port_arbiter: RTL

- Burst-level arbiter that shares the single SDRAM/MMU command port between two requesters:
  - the display read path, which refills the LCD read FIFO;
  - the SPI image loader, which writes received slides.
- Sits between both requesters and the MMU, clocked on iCLK_50.
- Display has fixed priority; a streak limiter keeps the loader from starving while a slide loads during playback.

---
 rtl/mmu_arb_pkg.sv | 12 +
 rtl/arb_streak_limiter.sv | 48 ++++
 rtl/sdram_port_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mmu_arb_pkg.sv
// Shared types and defaults for the SDRAM/MMU command-port arbiter.
`timescale 1ns/1ps
package mmu_arb_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 32;
  localparam int LEN_W      = 8;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} arb_state_t;
  typedef enum logic       {OWN_DISP, OWN_LOAD}    owner_t;

endpackage

// File: rtl/arb_streak_limiter.sv
// IDLE-time grant decision: display has priority unless the loader has been
// passed over MAX_STREAK times in a row.
`timescale 1ns/1ps
module arb_streak_limiter
  import mmu_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic   iCLK_50,
  input  logic   iRST,
  input  logic   arb_en,
  input  logic   disp_req,
  input  logic   load_req,
  output logic   grant,
  output owner_t grant_owner
);

  localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  logic [STREAK_W-1:0] streak;
  logic                load_wins;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant       = 1'b0;
    load_wins   = 1'b0;
    grant_owner = OWN_DISP;
    if (arb_en && (disp_req || load_req)) begin
      grant     = 1'b1;
      load_wins = load_req && (!disp_req || (streak == STREAK_MAX));
      if (load_wins) grant_owner = OWN_LOAD;
    end
  end

  // The streak only grows while the loader is actually waiting behind the display.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      streak <= '0;
    end else if (grant) begin
      if (grant_owner == OWN_LOAD || !load_req)
        streak <= '0;
      else if (streak != STREAK_MAX)
        streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Burst-level arbiter sharing the MMU command port between the display read
// path and the SPI image loader.
`timescale 1ns/1ps
module sdram_port_arbiter
  import mmu_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_STREAK = 4
) (
  input  logic              iCLK_50,
  input  logic              iRST,
  input  logic              iDisp_Req,
  input  logic [ADDR_W-1:0] iDisp_Addr,
  input  logic [LEN_W-1:0]  iDisp_Len,
  output logic              oDisp_Gnt,
  output logic              oDisp_Done,
  input  logic              iLoad_Req,
  input  logic [ADDR_W-1:0] iLoad_Addr,
  input  logic [LEN_W-1:0]  iLoad_Len,
  input  logic [DATA_W-1:0] iLoad_Wdata,
  output logic              oLoad_Ack,
  output logic              oLoad_Gnt,
  output logic              oLoad_Done,
  output logic              oMem_Cmd_Valid,
  input  logic              iMem_Cmd_Ready,
  output logic              oMem_Write,
  output logic [ADDR_W-1:0] oMem_Addr,
  output logic [LEN_W-1:0]  oMem_Len,
  output logic [DATA_W-1:0] oMem_Wdata,
  input  logic              iMem_Beat
);

  arb_state_t        state, state_next;
  owner_t            owner_q, grant_owner;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic              write_q;
  logic              last_beat;

  arb_streak_limiter #(.MAX_STREAK(MAX_STREAK)) u_streak (
    .iCLK_50     (iCLK_50),
    .iRST        (iRST),
    .arb_en      (state == IDLE),
    .disp_req    (iDisp_Req),
    .load_req    (iLoad_Req),
    .grant       (grant),
    .grant_owner (grant_owner)
  );

  assign last_beat = (state == DATA) && iMem_Beat && (beat_cnt == len_q);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant)          state_next = CMD;
      CMD:     if (iMem_Cmd_Ready) state_next = DATA;
      DATA:    if (last_beat)      state_next = DONE;
      DONE:                        state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // NOTE: iRST is asynchronous so a mid-burst reset drops ownership at once,
  // without waiting for a clock edge or emitting a Done pulse.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // Burst fields are latched once per grant and held stable through DONE.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      owner_q  <= OWN_DISP;
      addr_q   <= '0;
      len_q    <= '0;
      write_q  <= 1'b0;
      beat_cnt <= '0;
    end else if (state == IDLE && grant) begin
      owner_q  <= grant_owner;
      addr_q   <= (grant_owner == OWN_LOAD) ? iLoad_Addr : iDisp_Addr;
      len_q    <= (grant_owner == OWN_LOAD) ? iLoad_Len  : iDisp_Len;
      write_q  <= (grant_owner == OWN_LOAD);
      beat_cnt <= '0;
    end else if (state == DATA && iMem_Beat && !last_beat) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_comb begin
    oDisp_Gnt      = (state != IDLE) && (owner_q == OWN_DISP);
    oLoad_Gnt      = (state != IDLE) && (owner_q == OWN_LOAD);
    oDisp_Done     = (state == DONE) && (owner_q == OWN_DISP);
    oLoad_Done     = (state == DONE) && (owner_q == OWN_LOAD);
    oLoad_Ack      = (state == DATA) && (owner_q == OWN_LOAD) && iMem_Beat;
    oMem_Cmd_Valid = (state == CMD);
    oMem_Write     = write_q;
    oMem_Addr      = addr_q;
    oMem_Len       = len_q;
    oMem_Wdata     = iLoad_Wdata;
  end

endmodule
